lock_key_loader: RTL
====================

LOCK_KEY_LOADER -- requirements
Module: lock_key_loader

Interface
REQ-001 SHALL have parameter KEY_W, default 53: width of the logic-locking key bus.
REQ-002 SHALL have parameter NUM_KEY_BYTES, default 7: ceil(KEY_W/8), the number of key bytes per load.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset; synchronous, active-low.
REQ-005 SHALL have port start, input, 1: pulse that begins a key load.
REQ-006 SHALL have port zeroize, input, 1: clears the key immediately.
REQ-007 SHALL have port in_valid, input, 1: source offers in_data.
REQ-008 SHALL have port in_data, input, 8: key byte or CRC byte.
REQ-009 SHALL have port in_ready, output, 1: loader accepts in_data.
REQ-010 SHALL have port key_out, output, KEY_W: key driven to the locked netlist's keyinput bits; bit i feeds keyinput i.
REQ-011 SHALL have port key_valid, output, 1: key_out holds a committed, CRC-checked key.
REQ-012 SHALL have port busy, output, 1: high in LOAD or CHECK.
REQ-013 SHALL have port error, output, 1: the last load failed its CRC.

Function
REQ-014 SHALL implement the states IDLE, LOAD, CHECK, ARMED and ERROR.
REQ-015 A byte SHALL transfer only on a clock edge where in_valid and in_ready are both high; in_ready SHALL be high only in LOAD.
REQ-016 A load SHALL accept exactly NUM_KEY_BYTES+1 beats: key bytes first, little-endian (beat 0 goes to staging bits [7:0]), then one CRC byte.
REQ-017 CRC SHALL be CRC-8: polynomial 0x07, init 0x00, no reflection, no final XOR, computed over all NUM_KEY_BYTES key bytes, including the padding bits above KEY_W-1.
REQ-018 Padding bits (staging bits [55:53] at default parameters) SHALL be discarded and never reach key_out.
REQ-019 After the CRC beat is accepted, the FSM SHALL spend exactly one cycle in CHECK, then move to ARMED on a CRC match or to ERROR on a mismatch.
REQ-020 key_out SHALL update and key_valid SHALL rise at the second rising edge after the edge that accepted the CRC byte.
REQ-021 key_out SHALL be all-zero whenever key_valid is low, so no partially loaded key ever reaches the locked netlist.
REQ-022 start SHALL move IDLE, ARMED or ERROR to LOAD. Entering LOAD SHALL clear the beat counter, CRC, staging register, key_valid, key_out and error.
REQ-023 start in LOAD SHALL restart the load and discard bytes already accepted; a byte presented on the same edge SHALL be dropped.
REQ-024 start in CHECK SHALL be ignored.
REQ-025 zeroize SHALL, in any state, move the FSM to IDLE on the next edge and clear key_out, key_valid, error and staging.
REQ-026 When zeroize and start are both high, zeroize SHALL win.
REQ-027 ERROR SHALL hold error=1 and key_valid=0 until start or zeroize.
REQ-028 ARMED SHALL hold key_out stable indefinitely while start and zeroize stay low.
REQ-029 The beat counter SHALL never exceed NUM_KEY_BYTES; in_valid outside LOAD SHALL be ignored.

Reset
REQ-030 When rst_n=0 at a rising edge, the block SHALL enter IDLE with key_out=0, key_valid=0, busy=0, error=0, in_ready=0, counter=0 and CRC=0x00.
REQ-031 Reset SHALL take precedence over zeroize and start; reset mid-load SHALL discard all staged bytes.

Structure
REQ-032 A shared package lock_key_pkg SHALL hold KEY_W, NUM_KEY_BYTES, CRC8_POLY (0x07), CRC8_INIT (0x00) and the state enum type.
REQ-033 CRC arithmetic SHALL live in one combinational sub-module, crc8_byte_update (8-bit CRC in, byte in, 8-bit CRC out), instantiated once.
REQ-034 key_out SHALL be a registered output feeding the locked netlist's keyinput vector with no combinational path from in_data.

Verification
REQ-035 Reset, start, then 7 bytes of 0x00 plus CRC 0x00 with in_valid held high -> key_valid=1 two edges after the CRC beat, key_out=0, error=0.
REQ-036 Bytes 0xFF x7 plus the CRC from the model -> key_out = 53'h1F_FFFF_FFFF_FFFF, with padding bits discarded.
REQ-037 Bytes 0x00 x7 plus CRC 0x01 -> state ERROR, error=1, key_valid=0, key_out=0; a later start clears error.
REQ-038 start after 4 bytes of 0xA5, then a full valid load of 0x3C bytes -> key_out built only from 0x3C bytes.
REQ-039 zeroize and start together while ARMED -> next edge IDLE, key_out=0, key_valid=0, in_ready=0.
REQ-040 in_valid toggled randomly (about 50%) during a load -> same key_out as a back-to-back load; no beat lost or duplicated.

Source files
------------

// File: rtl/lock_key_pkg.sv
// Shared constants and FSM state type for the logic-locking key loader.
package lock_key_pkg;

  localparam int unsigned KEY_W         = 53;
  localparam int unsigned NUM_KEY_BYTES = 7;
  localparam logic [7:0]  CRC8_POLY     = 8'h07;
  localparam logic [7:0]  CRC8_INIT     = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_ARMED,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/crc8_byte_update.sv
// One-byte CRC-8 step: MSB-first, no reflection, no final XOR.
module crc8_byte_update
  import lock_key_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data_in;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/lock_key_loader.sv
// Loads a CRC-protected key byte stream and drives the locked netlist's key
// inputs only once the whole key has been checked.
module lock_key_loader
  import lock_key_pkg::*;
#(
  parameter int unsigned KEY_W         = lock_key_pkg::KEY_W,
  parameter int unsigned NUM_KEY_BYTES = lock_key_pkg::NUM_KEY_BYTES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             zeroize,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             error
);

  localparam int unsigned CNT_W   = $clog2(NUM_KEY_BYTES + 1);
  localparam int unsigned STAGE_W = 8 * NUM_KEY_BYTES;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         crc;
  logic [7:0]         crc_next;
  logic [STAGE_W-1:0] staging;
  logic               crc_ok;
  logic               do_load;
  logic               accept;

  crc8_byte_update u_crc (
    .crc_in  (crc),
    .data_in (in_data),
    .crc_out (crc_next)
  );

  assign do_load = start && (state != ST_CHECK);
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || zeroize) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      crc       <= CRC8_INIT;
      staging   <= '0;
      crc_ok    <= 1'b0;
      key_out   <= '0;
      key_valid <= 1'b0;
      error     <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else if (do_load) begin
      // start also restarts an in-progress load; a byte on this edge is dropped
      state     <= ST_LOAD;
      cnt       <= '0;
      crc       <= CRC8_INIT;
      staging   <= '0;
      crc_ok    <= 1'b0;
      key_out   <= '0;
      key_valid <= 1'b0;
      error     <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b1;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (cnt != CNT_W'(NUM_KEY_BYTES)) begin
              // shifting in from the top leaves beat 0 in staging[7:0]
              staging <= {in_data, staging[STAGE_W-1:8]};
              crc     <= crc_next;
              cnt     <= cnt + 1'b1;
            end else begin
              crc_ok   <= (in_data == crc);
              state    <= ST_CHECK;
              in_ready <= 1'b0;
            end
          end
        end
        ST_CHECK: begin
          busy  <= 1'b0;
          state <= crc_ok ? ST_ARMED : ST_ERROR;
          error <= !crc_ok;
        end
        ST_ARMED: begin
          // commit one cycle after entering ARMED; padding bits are dropped here
          if (!key_valid) begin
            key_out   <= staging[KEY_W-1:0];
            key_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
